imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction memory word-address width (256 words).
REQ-002 SHALL have parameter: DATA_W, 32, instruction word width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have port: start  in  1  begin-load request; sampled in IDLE and DONE only.
REQ-006 SHALL have port: word_count  in  ADDR_W+1  number of words to load; latched on the accepted start.
REQ-007 SHALL have port: in_valid  in  1  byte-stream valid.
REQ-008 SHALL have port: in_data  in  8  byte-stream data.
REQ-009 SHALL have port: in_ready  out  1  byte-stream ready.
REQ-010 SHALL have port: mem_we  out  1  instruction memory write enable (one-cycle pulse).
REQ-011 SHALL have port: mem_addr  out  ADDR_W  instruction memory word address.
REQ-012 SHALL have port: mem_wdata  out  DATA_W  instruction memory write data.
REQ-013 SHALL have port: cpu_hold  out  1  holds the processor in reset while a load is in progress.
REQ-014 SHALL have port: busy  out  1  a load is in progress.
REQ-015 SHALL have port: done  out  1  load complete; held until the next accepted start.
REQ-016 SHALL have port: err  out  1  checksum mismatch; valid while done=1.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CHECK, DONE.
REQ-018 SHALL transition IDLE/DONE->LOAD on start=1 with word_count!=0, clearing done, err, the word index and the byte counter.
REQ-019 SHALL transition IDLE/DONE->DONE on start=1 with word_count=0, performing no writes; done=1 and err=0 on the next cycle.
REQ-020 SHALL clamp a word_count above 2^ADDR_W to 2^ADDR_W.
REQ-021 SHALL drive in_ready=1 only in LOAD and CHECK, with a byte accepted only on in_valid&&in_ready.
REQ-022 SHALL assemble bytes big-endian: the 1st accepted byte goes to [31:24] and the 4th to [7:0].
REQ-023 SHALL, in LOAD, pulse mem_we for exactly one cycle on the cycle after the 4th byte is accepted, with mem_addr set to the word index (starting at 0) and mem_wdata set to the assembled word.
REQ-024 SHALL increment the word index after each write; in_ready remains 1 during the write cycle, giving back-to-back throughput of 1 byte per cycle.
REQ-025 SHALL, after the write of the last word, go to CHECK when LOADER_CHECKSUM_EN is defined and to DONE otherwise.
REQ-026 SHALL hold mem_addr stable and mem_we=0 whenever no write is occurring.
REQ-027 SHALL drive cpu_hold=busy=1 in LOAD and CHECK and 0 in IDLE and DONE.
REQ-028 SHALL ignore start while in LOAD or CHECK.
REQ-029 SHALL ignore in_valid and leave the byte unconsumed in IDLE and DONE.
REQ-030 SHALL allow the index to reach 2^ADDR_W-1 without wrapping; no write to address 0 follows a 256-word load.

Reset
REQ-031 SHALL, on rst=1 and at any time, immediately return to IDLE, discard any partial word and running sum, and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0.
REQ-032 SHALL require a new start after reset, because a load interrupted by reset does not resume.

Configuration
REQ-033 SHALL, with LOADER_CHECKSUM_EN defined, keep a 32-bit modulo-2^32 sum of the written words; in CHECK it accepts 4 further bytes (big-endian trailer, not written to memory), then sets err=1 if sum+trailer!=0, and goes to DONE.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, have no CHECK state, no sum register, no trailer, and err tied to 0.

Structure
REQ-035 SHALL place the FSM state enum, ADDR_W/DATA_W defaults and BYTES_PER_WORD=4 in a shared package, imem_pkg.
REQ-036 SHALL use one sub-module, word_assembler, comprising a byte counter and a shift register that emits word_valid for one cycle with the 32-bit word, and SHALL instantiate it for both data and trailer assembly.

Verification
REQ-037 SHALL cover: start, word_count=2, bytes 00 00 80 20 20 10 00 78 -> mem_we pulses at addr 0 with 0x00008020 and addr 1 with 0x20100078, then done=1 and cpu_hold=0.
REQ-038 SHALL cover: in_valid toggled every other cycle during a 3-word load -> identical writes with no extra mem_we pulses and no dropped bytes.
REQ-039 SHALL cover: word_count=0 -> done=1 one cycle after start, mem_we never asserted.
REQ-040 SHALL cover: word_count=256 -> the last write is at addr 255, followed by no write to addr 0; word_count=300 behaves identically.
REQ-041 SHALL cover: rst asserted after 6 bytes of a 2-word load -> all outputs return to reset values asynchronously; a new 1-word load afterwards writes addr 0 correctly.
REQ-042 SHALL cover, with LOADER_CHECKSUM_EN: words 0x00000001 and 0x00000002 with trailer 0xFFFFFFFD -> err=0; with trailer 0xFFFFFFFE -> err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default sizes,
// bytes per word and the loader FSM state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
`timescale 1ns/1ps
package imem_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects bytes big-endian (first byte lands in the MSBs)
// and emits the finished word with a one-cycle word_valid pulse on the cycle
// after its last byte is taken. byte_idx tells the parent which byte slot
// the next accepted byte will fill.
`timescale 1ns/1ps
module word_assembler
  import imem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              byte_valid,
  input  logic [7:0]                        byte_data,
  output logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx,
  output logic                              word_valid,
  output logic [DATA_W-1:0]                 word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  logic [DATA_W-1:0] shreg;

  // Shift bytes in MSB-first; on the final byte publish the word and pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        shreg    <= '0;
      end else if (byte_valid) begin
        shreg <= {shreg[DATA_W-9:0], byte_data};
        if (byte_idx == LAST_IDX) begin
          byte_idx   <= '0;
          word_valid <= 1'b1;
          word       <= {shreg[DATA_W-9:0], byte_data};
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a valid/ready source into instruction
// memory as big-endian words while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the data words a
// 4-byte big-endian trailer is taken and err flags sum+trailer != 0.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready.
// The source must hold in_data stable while in_valid=1 and in_ready=0;
// in_ready never depends combinationally on in_valid.
`timescale 1ns/1ps
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W:0]  MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] last_idx;
  logic              accept;
  logic              start_go;
  logic              load_byte;
  logic              last_word;
  logic [ADDR_W:0]   clamped_count;

  logic [CNT_W-1:0]  data_byte_idx;
  logic              data_word_valid;
  logic [DATA_W-1:0] data_word;

  // Handshake, start qualification and the clamped word count.
  always_comb begin
    accept        = in_valid && in_ready;
    start_go      = start && ((state == IDLE) || (state == DONE));
    load_byte     = accept && (state == LOAD);
    last_word     = (mem_addr == last_idx);
    clamped_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  end

  word_assembler #(.DATA_W(DATA_W)) u_data_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go),
    .byte_valid (load_byte),
    .byte_data  (in_data),
    .byte_idx   (data_byte_idx),
    .word_valid (data_word_valid),
    .word       (data_word)
  );

  // The write strobe is the assembler's registered one-cycle pulse; data
  // bytes only reach the assembler in LOAD so it cannot fire elsewhere.
  assign mem_we    = data_word_valid;
  assign mem_wdata = data_word;
  assign cpu_hold  = busy;
  assign dbg_state = state;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              err_r;
  logic              trl_byte;
  logic [CNT_W-1:0]  trl_byte_idx;
  logic              trl_word_valid;
  logic [DATA_W-1:0] trl_word;

  // Trailer bytes are only taken while checking.
  always_comb trl_byte = accept && (state == CHECK);

  word_assembler #(.DATA_W(DATA_W)) u_trl_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go),
    .byte_valid (trl_byte),
    .byte_data  (in_data),
    .byte_idx   (trl_byte_idx),
    .word_valid (trl_word_valid),
    .word       (trl_word)
  );

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Loader FSM with registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      last_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
      err_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_go) begin
`ifdef LOADER_CHECKSUM_EN
            err_r <= 1'b0;
            sum   <= '0;
`endif
            if (word_count == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state    <= LOAD;
              done     <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              mem_addr <= '0;
              last_idx <= ADDR_W'(clamped_count - 1'b1);
            end
          end
        end

        LOAD: begin
          // Stop taking bytes once the final data byte is in.
          if (load_byte && (data_byte_idx == LAST_BYTE) && last_word)
            in_ready <= 1'b0;
          if (data_word_valid) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + data_word;
`endif
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CHECK;
              in_ready <= 1'b1;
`else
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
`endif
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (trl_byte && (trl_byte_idx == LAST_BYTE))
            in_ready <= 1'b0;
          if (trl_word_valid) begin
            err_r <= ((sum + trl_word) != '0);
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams are checked against a model
// that derives the expected memory writes and error flag directly from the
// byte list, word count and trailer.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  logic [7:0]  tx_bytes[$];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Write monitor: record every write strobe away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] wc);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    tx_bytes.delete();
    for (int i = 0; i < nbytes; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // Full load: model, drive, then scoreboard the writes and the final flags.
  task automatic do_load(input logic [ADDR_W:0] wc, input int gap_mode,
                         input logic [31:0] trailer);
    int n;
    int waited;
    logic [31:0] w;
    logic [31:0] sum;
    logic exp_err;
    logic [39:0] e;
    logic [39:0] o;
    n = (int'(wc) > 256) ? 256 : int'(wc);
    obs_q.delete();
    exp_q.delete();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      w = (32'(tx_bytes[4*i]) << 24) | (32'(tx_bytes[4*i+1]) << 16) |
          (32'(tx_bytes[4*i+2]) << 8) | 32'(tx_bytes[4*i+3]);
      exp_q.push_back({8'(i), w});
      sum = sum + w;
    end
`ifdef LOADER_CHECKSUM_EN
    exp_err = (n > 0) && ((sum + trailer) != 0);
`else
    exp_err = 1'b0;
`endif
    pulse_start(wc);
    total++;
    if ({busy, cpu_hold} !== 2'b11) begin
      bad++;
      $display("FAIL load_busy: busy,cpu_hold=%b required 11", {busy, cpu_hold});
    end
    for (int i = 0; i < 4*n; i++) begin
      if (gap_mode == 1 && i > 0) @(negedge clk);
      if (gap_mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(tx_bytes[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    for (int k = 0; k < 4; k++) send_byte(trailer[31-8*k -: 8]);
`else
    if (trailer == 32'h0) begin end
`endif
    waited = 0;
    while (done !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL load_done: done=%b required 1", done);
    end
    total++;
    if ({busy, cpu_hold, in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL load_idle_flags: busy,cpu_hold,in_ready=%b required 000",
               {busy, cpu_hold, in_ready});
    end
    total++;
    if (err !== exp_err) begin
      bad++;
      $display("FAIL load_err: err=%b required %b", err, exp_err);
    end
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL write_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL write_entry: addr/data=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready,we,hold,busy,done,err=%b required 000000",
               {in_ready, mem_we, cpu_hold, busy, done, err});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 40'h0) begin
      bad++;
      $display("FAIL reset_mem: addr/data=%h required 0", {mem_addr, mem_wdata});
    end
  endtask

  task automatic test_zero_count();
    obs_q.delete();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL zero_pre_done: done=%b required 0", done);
    end
    pulse_start(0);
    total++;
    if ({done, err, busy} !== 3'b100) begin
      bad++;
      $display("FAIL zero_done: done,err,busy=%b required 100", {done, err, busy});
    end
    in_valid = 1'b1;
    in_data = 8'h5a;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_in_ready: in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b0;
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL zero_writes: got %0d writes required 0", obs_q.size());
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[8];
    b = '{8'h00, 8'h00, 8'h80, 8'h20, 8'h20, 8'h10, 8'h00, 8'h78};
    tx_bytes.delete();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(b[i]);
    do_load(2, 0, $urandom);
  endtask

  task automatic test_gapped();
    fill_random(12);
    do_load(3, 1, $urandom);
  endtask

  task automatic test_random_loads();
    int wc;
    for (int r = 0; r < 4; r++) begin
      wc = $urandom_range(1, 8);
      fill_random(4*wc);
      do_load(9'(wc), 2, $urandom);
    end
  endtask

  task automatic test_full_depth();
    fill_random(1024);
    do_load(256, 0, $urandom);
    fill_random(1024);
    do_load(300, 0, $urandom);
  endtask

  task automatic test_reset_midload();
    logic [31:0] w0;
    fill_random(8);
    obs_q.delete();
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(tx_bytes[i]);
    w0 = (32'(tx_bytes[0]) << 24) | (32'(tx_bytes[1]) << 16) |
         (32'(tx_bytes[2]) << 8) | 32'(tx_bytes[3]);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {8'h00, w0}) begin
      bad++;
      $display("FAIL midload_first_write: writes=%0d required 1 of %h", obs_q.size(), {8'h00, w0});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset_ctrl: ready,we,hold,busy,done,err=%b required 000000",
               {in_ready, mem_we, cpu_hold, busy, done, err});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 40'h0) begin
      bad++;
      $display("FAIL async_reset_mem: addr/data=%h required 0", {mem_addr, mem_wdata});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(4);
    do_load(1, 0, $urandom);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b[8];
    b = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    tx_bytes.delete();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(b[i]);
    do_load(2, 0, 32'hFFFF_FFFD);
    do_load(2, 2, 32'hFFFF_FFFE);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_count();
    test_basic();
    test_gapped();
    test_random_loads();
    test_full_depth();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
